// File: rtl/ifexp_operand_queue_pkg.sv
// Shared types and constants for the IfExp operand queue.
// Operand pair layout, default depth and result width.
package ifexp_operand_queue_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int RES_W     = 16;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] b;
  } operand_t;

endpackage

// File: rtl/ifexp_operand_queue_ifexp.sv
// IfExp datapath: XOUT = (A > B) ? A : B + 1, unsigned.
// A is zero-extended; B + 1 wraps modulo 2^16.
module ifexp_operand_queue_ifexp
  import ifexp_operand_queue_pkg::*;
(
  input  logic [7:0]       A,
  input  logic [15:0]      B,
  output logic [RES_W-1:0] XOUT
);

  logic [15:0] a_ext;

  assign a_ext = {8'h00, A};
  assign XOUT  = (a_ext > B) ? a_ext : (B + 16'd1);

endmodule

// File: rtl/ifexp_operand_queue.sv
// Operand FIFO feeding IfExp, with a registered valid/ready result slot.
// Count register disambiguates full/empty; pointers wrap naturally.
module ifexp_operand_queue
  import ifexp_operand_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [7:0]       IN_A,
  input  logic [15:0]      IN_B,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [RES_W-1:0] OUT_X,
  output logic [LW-1:0]    LEVEL
);

  localparam int            PW   = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  operand_t         mem_q [DEPTH];
  operand_t         head;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [RES_W-1:0] out_x_q, out_x_d;
  logic [RES_W-1:0] xout;
  logic             push, pop;

  assign IN_READY  = (count_q != FULL) & ~RST;
  assign push      = IN_VALID & IN_READY;
  assign pop       = (count_q != '0) & (~out_valid_q | OUT_READY);
  assign head      = mem_q[rd_ptr_q];
  assign OUT_VALID = out_valid_q;
  assign OUT_X     = out_x_q;
  assign LEVEL     = count_q;

  ifexp_operand_queue_ifexp u_ifexp (
    .A    (head.a),
    .B    (head.b),
    .XOUT (xout)
  );

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_x_d     = out_x_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
    // Capture on pop; otherwise a taken result empties the slot
    if (pop) begin
      out_valid_d = 1'b1;
      out_x_d     = xout;
    end else if (OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= '{a: IN_A, b: IN_B};
  end

endmodule

// File: tb/tb_ifexp_operand_queue.sv
// Self-checking bench for ifexp_operand_queue.
// Vector table plus a scoreboard fed at accepted pushes.
module tb_ifexp_operand_queue;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [7:0]  IN_A;
  logic [15:0] IN_B;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [15:0] OUT_X;
  logic [2:0]  LEVEL;

  int errors = 0;
  int checks = 0;
  logic [15:0] sb_q[$];

  typedef struct {
    logic [7:0]  a;
    logic [15:0] b;
    logic [15:0] x;
  } vec_t;

  vec_t vt[6];

  ifexp_operand_queue #(.DEPTH(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_A      (IN_A),
    .IN_B      (IN_B),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_X     (OUT_X),
    .LEVEL     (LEVEL)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] model(logic [7:0] a, logic [15:0] b);
    logic [15:0] ae;
    ae = {8'h00, a};
    return (ae > b) ? ae : 16'(b + 16'd1);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Inputs change 1 after posedge, so negedge shows next edge's handshakes
  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      sb_q.delete();
    end else begin
      if (IN_VALID === 1'b1 && IN_READY === 1'b1)
        sb_q.push_back(model(IN_A, IN_B));
      if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got %0h expected none", OUT_X);
        end else begin
          logic [15:0] e;
          e = sb_q.pop_front();
          if (OUT_X !== e) begin
            errors++;
            $display("FAIL sb_order: got %0h expected %0h", OUT_X, e);
          end
        end
      end
    end
  end

  initial begin
    int lat, idx, acc, gaps, seen, total, maxlvl, nv;
    logic [15:0] got[$];
    logic [15:0] held;

    vt[0] = '{8'h20, 16'h0010, 16'h0020};
    vt[1] = '{8'h05, 16'h0005, 16'h0006};
    vt[2] = '{8'h00, 16'hFFFF, 16'h0000};
    vt[3] = '{8'hFF, 16'h00FE, 16'h00FF};
    vt[4] = '{8'h80, 16'h0100, 16'h0101};
    vt[5] = '{8'hFF, 16'h00FF, 16'h0100};

    // 1. reset with IN_VALID held high
    RST = 1'b1; IN_VALID = 1'b1; IN_A = 8'h11; IN_B = 16'h0001;
    OUT_READY = 1'b0;
    step();
    check("rst_in_ready", IN_READY, 0);
    step();
    check("rst_level", LEVEL, 0);
    RST = 1'b0; IN_VALID = 1'b0;
    #1;
    check("post_rst_in_ready", IN_READY, 1);
    check("post_rst_out_valid", OUT_VALID, 0);
    check("post_rst_out_x", OUT_X, 0);
    check("post_rst_level", LEVEL, 0);

    // 2. single pairs, one at a time
    OUT_READY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      IN_VALID = 1'b1; IN_A = vt[i].a; IN_B = vt[i].b;
      step();
      IN_VALID = 1'b0;
      check("single_no_bypass", OUT_VALID, 0);
      lat = 0;
      while (OUT_VALID !== 1'b1 && lat < 5) begin
        step();
        lat++;
      end
      check("single_latency", lat, 1);
      check($sformatf("single_x[%0d]", i), OUT_X, vt[i].x);
    end
    step();
    check("single_drained", OUT_VALID, 0);

    // 3. backpressure: 6 pairs, consumer stalled
    OUT_READY = 1'b0; IN_VALID = 1'b1; IN_A = 8'h00;
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      IN_B = 16'(idx);
      acc = int'(IN_READY);
      step();
      idx += acc;
    end
    check("bp_accepted", idx, 5);
    check("bp_in_ready", IN_READY, 0);
    check("bp_level", LEVEL, 4);
    check("bp_out_valid", OUT_VALID, 1);
    check("bp_out_x", OUT_X, 16'h0001);
    held = OUT_X;
    step(); step();
    check("bp_stable", OUT_X, held);
    OUT_READY = 1'b1;
    got.delete();
    for (int c = 0; c < 15; c++) begin
      IN_VALID = (idx < 6);
      IN_B = 16'(idx);
      acc = int'(IN_VALID && IN_READY);
      if (OUT_VALID) got.push_back(OUT_X);
      step();
      idx += acc;
    end
    IN_VALID = 1'b0;
    check("bp_sixth_accepted", idx, 6);
    check("bp_count", got.size(), 6);
    for (int k = 0; k < 6 && k < got.size(); k++)
      check($sformatf("bp_order[%0d]", k), got[k], 16'(k + 1));

    // 4. streaming
    OUT_READY = 1'b1; IN_A = 8'h00;
    gaps = 0; seen = 0; total = 0; maxlvl = 0;
    for (int c = 0; c < 20; c++) begin
      IN_VALID = 1'b1; IN_B = 16'h0100 + 16'(c);
      if (OUT_VALID) begin
        seen = 1; total++;
      end else if (seen != 0) begin
        gaps++;
      end
      if (int'(LEVEL) > maxlvl) maxlvl = int'(LEVEL);
      step();
    end
    IN_VALID = 1'b0;
    nv = 0;
    while ((OUT_VALID || LEVEL != 0) && nv < 10) begin
      if (OUT_VALID) total++;
      step();
      nv++;
    end
    check("stream_level_max", maxlvl <= 1, 1);
    check("stream_gaps", gaps, 0);
    check("stream_total", total, 20);
    check("stream_drain_bound", nv < 10, 1);

    // 5. simultaneous push/pop while full
    OUT_READY = 1'b0; IN_VALID = 1'b1; IN_A = 8'hC0; IN_B = 16'h0040;
    nv = 0;
    while (LEVEL != 3'd4 && nv < 10) begin
      step();
      nv++;
    end
    check("full_level", LEVEL, 4);
    check("full_out_valid", OUT_VALID, 1);
    check("full_in_ready", IN_READY, 0);
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;
    check("full_pop_level", LEVEL, 3);
    check("full_pop_in_ready", IN_READY, 1);
    step();
    IN_VALID = 1'b0;
    check("full_refill_level", LEVEL, 4);

    // 6. reset mid-operation
    OUT_READY = 1'b1;
    step();
    OUT_READY = 1'b0;
    check("mid_level", LEVEL, 3);
    check("mid_out_valid", OUT_VALID, 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("mid_rst_out_valid", OUT_VALID, 0);
    check("mid_rst_level", LEVEL, 0);
    OUT_READY = 1'b1;
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (OUT_VALID) nv++;
    end
    check("mid_rst_quiet", nv, 0);
    check("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
